// File: rtl/signal_debounce_filter.sv
// signal_debounce_filter
//   Input conditioning stage that sits upstream of the hold-high pulse
//   extender. It brings an asynchronous level into the clock domain through a
//   flop chain, then accepts a new level only after it has been seen for N
//   consecutive synchronised samples. Shorter glitches are rejected.
//
// Parameters:
//   COUNT_BW    - width of cfg_stable_count and of the qualification counter
//   SYNC_STAGES - synchroniser depth on signal_in (2..4)
//
// Ports:
//   clock            in   single clock, rising edge
//   reset            in   synchronous, active-high reset
//   signal_in        in   asynchronous raw level
//   cfg_stable_count in   consecutive samples needed (0 behaves as 1)
//   signal_out       out  debounced level, registered
//   rise_pulse       out  one-cycle strobe with signal_out 0->1
//   fall_pulse       out  one-cycle strobe with signal_out 1->0
//   glitch_count     out  [SIGNAL_DEBOUNCE_GLITCH_COUNT_EN] saturating count
//                         of aborted qualifications
//   glitch_count_clr in   [SIGNAL_DEBOUNCE_GLITCH_COUNT_EN] synchronous clear,
//                         wins over a same-cycle increment
//
// Optional feature macro: SIGNAL_DEBOUNCE_GLITCH_COUNT_EN
module signal_debounce_filter #(
  parameter int COUNT_BW    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                signal_in,
  input  logic [COUNT_BW-1:0] cfg_stable_count,
`ifdef SIGNAL_DEBOUNCE_GLITCH_COUNT_EN
  input  logic                glitch_count_clr,
  output logic [7:0]          glitch_count,
`endif
  output logic                signal_out,
  output logic                rise_pulse,
  output logic                fall_pulse
);

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] QUAL_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] QUAL_LOW    = 2'd3;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic [1:0]             state_reg, state_next;
  logic [COUNT_BW-1:0]    count_reg, count_next;
  logic                   out_reg, out_next;
  logic                   rise_reg, rise_next;
  logic                   fall_reg, fall_next;
  logic                   glitch_inc;
  logic [COUNT_BW:0]      count_inc;
  logic [COUNT_BW:0]      n_eff;

  // Plain shift chain, no logic between stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], signal_in};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // Threshold re-evaluated every cycle; one extra bit keeps count+1 from
  // wrapping and lets a lowered threshold be caught by the >= compare.
  assign n_eff     = (cfg_stable_count == '0) ? {{COUNT_BW{1'b0}}, 1'b1}
                                              : {1'b0, cfg_stable_count};
  assign count_inc = {1'b0, count_reg} + {{COUNT_BW{1'b0}}, 1'b1};

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    out_next   = out_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    glitch_inc = 1'b0;
    case (state_reg)
      STABLE_LOW: begin
        out_next = 1'b0;
        if (s) begin
          if (n_eff == {{COUNT_BW{1'b0}}, 1'b1}) begin
            state_next = STABLE_HIGH;
            out_next   = 1'b1;
            rise_next  = 1'b1;
            count_next = '0;
          end else begin
            state_next = QUAL_HIGH;
            count_next = {{(COUNT_BW-1){1'b0}}, 1'b1};
          end
        end
      end
      QUAL_HIGH: begin
        if (!s) begin
          state_next = STABLE_LOW;
          count_next = '0;
          glitch_inc = 1'b1;
        end else if (count_inc >= n_eff) begin
          state_next = STABLE_HIGH;
          out_next   = 1'b1;
          rise_next  = 1'b1;
          count_next = '0;
        end else begin
          count_next = count_inc[COUNT_BW-1:0];
        end
      end
      STABLE_HIGH: begin
        out_next = 1'b1;
        if (!s) begin
          if (n_eff == {{COUNT_BW{1'b0}}, 1'b1}) begin
            state_next = STABLE_LOW;
            out_next   = 1'b0;
            fall_next  = 1'b1;
            count_next = '0;
          end else begin
            state_next = QUAL_LOW;
            count_next = {{(COUNT_BW-1){1'b0}}, 1'b1};
          end
        end
      end
      QUAL_LOW: begin
        if (s) begin
          state_next = STABLE_HIGH;
          count_next = '0;
          glitch_inc = 1'b1;
        end else if (count_inc >= n_eff) begin
          state_next = STABLE_LOW;
          out_next   = 1'b0;
          fall_next  = 1'b1;
          count_next = '0;
        end else begin
          count_next = count_inc[COUNT_BW-1:0];
        end
      end
      default: begin
        // Unreachable with a 2-bit encoding; kept as a safe recovery path.
        state_next = STABLE_LOW;
        count_next = '0;
        out_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= STABLE_LOW;
      count_reg <= '0;
      out_reg   <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      out_reg   <= out_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign signal_out = out_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

`ifdef SIGNAL_DEBOUNCE_GLITCH_COUNT_EN
  logic [7:0] glitch_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      glitch_reg <= 8'h00;
    end else if (glitch_count_clr) begin
      glitch_reg <= 8'h00;
    end else if (glitch_inc && (glitch_reg != 8'hFF)) begin
      glitch_reg <= glitch_reg + 8'h01;
    end
  end

  assign glitch_count = glitch_reg;
`else
  // Abort detection only feeds the optional counter.
  logic unused_glitch;
  assign unused_glitch = glitch_inc;
`endif

endmodule

// File: tb/tb_signal_debounce_filter.sv
// Directed bench for signal_debounce_filter (SYNC_STAGES=2, COUNT_BW=10).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "after tick k" means the cycle following the k-th edge.
module tb_signal_debounce_filter;

  logic       clock = 1'b0;
  logic       reset;
  logic       signal_in;
  logic [9:0] cfg_stable_count;
  logic       signal_out;
  logic       rise_pulse;
  logic       fall_pulse;
`ifdef SIGNAL_DEBOUNCE_GLITCH_COUNT_EN
  logic       glitch_count_clr;
  logic [7:0] glitch_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  signal_debounce_filter #(.COUNT_BW(10), .SYNC_STAGES(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .signal_in       (signal_in),
    .cfg_stable_count(cfg_stable_count),
`ifdef SIGNAL_DEBOUNCE_GLITCH_COUNT_EN
    .glitch_count_clr(glitch_count_clr),
    .glitch_count    (glitch_count),
`endif
    .signal_out      (signal_out),
    .rise_pulse      (rise_pulse),
    .fall_pulse      (fall_pulse)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic o, input logic r, input logic f);
    check({tag, ".out"},  {31'd0, signal_out}, {31'd0, o});
    check({tag, ".rise"}, {31'd0, rise_pulse}, {31'd0, r});
    check({tag, ".fall"}, {31'd0, fall_pulse}, {31'd0, f});
  endtask

  logic in_pat [0:39];
  logic exp_o, prev_o;

  initial begin
    reset            = 1'b1;
    signal_in        = 1'b0;
    cfg_stable_count = 10'd4;
`ifdef SIGNAL_DEBOUNCE_GLITCH_COUNT_EN
    glitch_count_clr = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
`ifdef SIGNAL_DEBOUNCE_GLITCH_COUNT_EN
    check("reset.glitch", {24'd0, glitch_count}, 32'd0);
`endif
    tick();

    // 1) cfg=4: rising edge reaches signal_out 2+4 = 6 cycles later.
    signal_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      $display("rise_latency k=%0d out=%0b rise=%0b fall=%0b", k, signal_out, rise_pulse, fall_pulse);
      check_outs($sformatf("rise_latency[%0d]", k), k >= 6, k == 6, 1'b0);
    end
    signal_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      $display("fall_latency k=%0d out=%0b rise=%0b fall=%0b", k, signal_out, rise_pulse, fall_pulse);
      check_outs($sformatf("fall_latency[%0d]", k), k < 6, 1'b0, k == 6);
    end

    // 2) cfg=4: 3-cycle high glitch is rejected.
    signal_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) signal_in = 1'b0;
      tick();
      $display("glitch k=%0d out=%0b rise=%0b", k, signal_out, rise_pulse);
      check_outs($sformatf("glitch[%0d]", k), 1'b0, 1'b0, 1'b0);
    end
`ifdef SIGNAL_DEBOUNCE_GLITCH_COUNT_EN
    check("glitch_count_one", {24'd0, glitch_count}, 32'd1);
    for (int g = 0; g < 300; g++) begin
      signal_in = 1'b1;
      tick(); tick(); tick();
      signal_in = 1'b0;
      tick(); tick(); tick(); tick();
    end
    $display("glitch_sat count=%0h", glitch_count);
    check("glitch_count_sat", {24'd0, glitch_count}, 32'hFF);
    check_outs("glitch_sat", 1'b0, 1'b0, 1'b0);
    // High samples reach the FSM at ticks 3..5; the abort happens at tick 6.
    signal_in = 1'b1;
    tick(); tick(); tick();
    signal_in = 1'b0;
    tick(); tick();
    check("glitch_before_clr", {24'd0, glitch_count}, 32'hFF);
    glitch_count_clr = 1'b1;
    tick();
    glitch_count_clr = 1'b0;
    $display("glitch_clr count=%0h", glitch_count);
    check("glitch_clr_priority", {24'd0, glitch_count}, 32'd0);
    tick(); tick();
`endif

    // 3) cfg=0 then cfg=1: toggle every 5 cycles, output follows after 3.
    for (int t = 0; t < 40; t++) in_pat[t] = ((t / 5) % 2) == 1;
    for (int pass = 0; pass < 2; pass++) begin
      cfg_stable_count = (pass == 0) ? 10'd0 : 10'd1;
      prev_o = 1'b0;
      for (int t = 0; t < 40; t++) begin
        signal_in = in_pat[t];
        tick();
        exp_o = (t + 1 >= 3) ? in_pat[t - 2] : 1'b0;
        $display("toggle cfg=%0d c=%0d out=%0b rise=%0b fall=%0b", cfg_stable_count, t + 1,
                 signal_out, rise_pulse, fall_pulse);
        check_outs($sformatf("toggle_cfg%0d[%0d]", pass, t + 1), exp_o,
                   exp_o & ~prev_o, ~exp_o & prev_o);
        prev_o = exp_o;
      end
      signal_in = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      check_outs($sformatf("toggle_cfg%0d_end", pass), 1'b0, 1'b0, 1'b0);
    end

    // 4) cfg=8: reset after 5 qualifying samples discards the partial count.
    cfg_stable_count = 10'd8;
    signal_in = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset_mid out=%0b rise=%0b fall=%0b", signal_out, rise_pulse, fall_pulse);
    check_outs("reset_mid", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      $display("requal k=%0d out=%0b rise=%0b", k, signal_out, rise_pulse);
      check_outs($sformatf("requal[%0d]", k), k >= 10, k == 10, 1'b0);
    end
    signal_in = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check_outs("requal_end", 1'b0, 1'b0, 1'b0);

    // 5) cfg=10 lowered to 3 after 6 qualifying samples.
    cfg_stable_count = 10'd10;
    signal_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 8) cfg_stable_count = 10'd3;
      $display("cfg_drop k=%0d out=%0b rise=%0b", k, signal_out, rise_pulse);
      check_outs($sformatf("cfg_drop[%0d]", k), k >= 9, k == 9, 1'b0);
    end
    signal_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) signal_in = 1'b1;
      tick();
      $display("low2 k=%0d out=%0b fall=%0b", k, signal_out, fall_pulse);
      check_outs($sformatf("low2_reject[%0d]", k), 1'b1, 1'b0, 1'b0);
    end
    signal_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) signal_in = 1'b1;
      tick();
      $display("low3 k=%0d out=%0b rise=%0b fall=%0b", k, signal_out, rise_pulse, fall_pulse);
      check_outs($sformatf("low3_accept[%0d]", k), !(k >= 5 && k < 8), k == 8, k == 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/signal_debounce_filter.md
Name: signal_debounce_filter

Overview:
- Input conditioning stage that sits directly upstream of the hold-high pulse extender.
- Synchronises an asynchronous level input into the clock domain, then rejects glitches shorter than a configurable number of cycles.
- Drives a clean, registered level plus single-cycle rise/fall strobes; signal_out connects straight to the extender's signal_in.

Parameters:
COUNT_BW, 10, width of the stable-count config and the qualification counter
SYNC_STAGES, 2, number of synchroniser flops on signal_in (legal range 2..4)

Ports:
clock  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
signal_in  input  1  asynchronous raw level input
cfg_stable_count  input  COUNT_BW  consecutive synchronised samples needed to accept a new level; 0 treated as 1
signal_out  output  1  debounced level, registered
rise_pulse  output  1  one-cycle strobe, coincident with signal_out going 0->1
fall_pulse  output  1  one-cycle strobe, coincident with signal_out going 1->0

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While reset is sampled high, all state clears on the next clock edge:
  - sync chain = 0, state = STABLE_LOW, counter = 0;
  - signal_out, rise_pulse, fall_pulse = 0.
- Synchroniser: SYNC_STAGES flop chain. The last stage is the sample s. There is no logic between stages.
- Effective threshold: N = (cfg_stable_count == 0) ? 1 : cfg_stable_count. It is evaluated every cycle, never latched.
- States: STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW. Counter = consecutive qualifying samples seen so far.
- STABLE_LOW:
  - s == 1 and N == 1 -> STABLE_HIGH; signal_out <= 1; rise_pulse <= 1.
  - s == 1 and N > 1 -> QUAL_HIGH; counter <= 1.
  - Otherwise stay.
- QUAL_HIGH:
  - s == 0 -> STABLE_LOW; counter <= 0 (glitch rejected).
  - s == 1 and counter+1 >= N -> STABLE_HIGH; signal_out <= 1; rise_pulse <= 1; counter <= 0.
  - Otherwise counter <= counter+1.
- STABLE_HIGH and QUAL_LOW: exact mirror of the above with s inverted. The strobe is fall_pulse and signal_out <= 0.
- Arithmetic: counter+1 is computed at COUNT_BW+1 bits, so no wrap is possible. The counter never exceeds N-1 in a QUAL state.
- Threshold change mid-qualification: the >= compare means that if N drops to or below counter+1, the level is accepted on the next qualifying sample. If N rises, qualification simply continues.
- Strobes: rise_pulse and fall_pulse are high for exactly one cycle and never high together. Both are 0 in every cycle without a transition.
- Latency:
  - signal_in edge to s: SYNC_STAGES cycles.
  - s stable to signal_out change: N cycles.
  - Total: SYNC_STAGES + N cycles.
- Minimum accepted pulse: N consecutive samples. Anything shorter produces no output change and no strobe.
- Illegal state encoding -> STABLE_LOW next cycle, with outputs 0.
- Reset during a QUAL state discards the partial count. A level held after reset must fully requalify from STABLE_LOW.

Optional Feature:
- Macro: SIGNAL_DEBOUNCE_GLITCH_COUNT_EN.
- Defined:
  - Adds output port glitch_count [7:0] and input port glitch_count_clr [0:0].
  - glitch_count increments by 1 on each QUAL_HIGH->STABLE_LOW or QUAL_LOW->STABLE_HIGH abort and saturates at 8'hFF.
  - glitch_count_clr (synchronous, high) zeroes it and has priority over a same-cycle increment.
  - Reset value is 0.
- Not defined: both ports and the counter are absent; all other behaviour is identical.

Test Plan:
- SYNC_STAGES=2, cfg=4; signal_in rises at cycle 0 and holds high -> signal_out rises at cycle 6; rise_pulse high only in cycle 6; fall_pulse stays 0.
- cfg=4; a 3-cycle high glitch on signal_in -> signal_out stays 0 and no strobes; with the macro, glitch_count = 1. 300 such glitches -> glitch_count = 8'hFF. Asserting glitch_count_clr in the same cycle as a glitch abort -> 0.
- cfg=0 and cfg=1; signal_in toggles every 5 cycles -> signal_out follows with 3-cycle latency; one strobe per edge.
- cfg=8; signal_in high; reset asserted after 5 qualifying samples -> all outputs 0 the next cycle; after release, signal_out rises 2+8 cycles after the first post-reset sample.
- cfg=10; after 6 qualifying high samples, cfg drops to 3 -> signal_out rises on the next qualifying sample; a subsequent low of 2 cycles is rejected; a low of 3 cycles produces fall_pulse.
